// File: rtl/ctrl_pkg.sv
// Shared decode constants, ALUControl codes, FSM state and control payload types
// for the pipelined control unit.
package ctrl_pkg;

    localparam int unsigned ALU_CODE_W = 3;

    localparam logic [1:0] CLASS_DP  = 2'b01;
    localparam logic [1:0] CLASS_MEM = 2'b10;
    localparam logic [2:0] OP_CMP    = 3'b111;

    typedef logic [ALU_CODE_W-1:0] aluc_t;

    localparam aluc_t ALU_ADD = 3'b000;
    localparam aluc_t ALU_SUB = 3'b001;
    localparam aluc_t ALU_AND = 3'b010;
    localparam aluc_t ALU_ORR = 3'b011;
    localparam aluc_t ALU_EOR = 3'b100;
    localparam aluc_t ALU_MOD = 3'b101;
    localparam aluc_t ALU_EXP = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

    // Fields carried by the E stage register.
    typedef struct packed {
        logic  alusrc;
        logic  flagswrite;
        aluc_t aluctrl;
        logic  regwrite;
        logic  memtoreg;
        logic  memwrite;
    } ectrl_t;

    typedef struct packed {
        logic   regsrc;
        ectrl_t ex;
    } ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } mctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // ALU decoder: data-processing op field to ALUControl code.
    function automatic aluc_t alu_decode(input logic [2:0] op);
        aluc_t code;
        case (op)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SUB;
            3'b010:  code = ALU_AND;
            3'b011:  code = ALU_ORR;
            3'b100:  code = ALU_EOR;
            3'b101:  code = ALU_MOD;
            3'b110:  code = ALU_EXP;
            default: code = ALU_SUB;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational main + ALU decoder: instruction id to control payload.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int unsigned ID_W = 6
) (
    input  logic [ID_W-1:0] id,
    input  logic            id_valid,
    output ctrl_t           ctrl
);

    logic [1:0] cls;
    logic [2:0] op;
    logic       imm;

    assign cls = id[ID_W-1 -: 2];
    assign op  = id[3:1];
    assign imm = id[0];

    // Invalid ids and unused classes decode to an all-zero NOP.
    always_comb begin
        ctrl = CTRL_NOP;
        if (id_valid) begin
            case (cls)
                CLASS_DP: begin
                    ctrl.ex.alusrc = imm;
                    if (op == OP_CMP) begin
                        ctrl.ex.flagswrite = 1'b1;
                        ctrl.ex.aluctrl    = ALU_SUB;
                    end else begin
                        ctrl.ex.regwrite = 1'b1;
                        ctrl.ex.aluctrl  = alu_decode(op);
                    end
                end
                CLASS_MEM: begin
                    ctrl.ex.alusrc  = 1'b1;
                    ctrl.ex.aluctrl = ALU_ADD;
                    if (op[2]) begin
                        ctrl.regsrc      = 1'b1;
                        ctrl.ex.memwrite = 1'b1;
                    end else begin
                        ctrl.ex.memtoreg = 1'b1;
                        ctrl.ex.regwrite = 1'b1;
                    end
                end
                default: ctrl = CTRL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode into E/M/W registers with multi-cycle op handshake.
// Optional macro DECODE_ERR_EN adds a sticky illegal-class flag on illegal_o.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned           ID_W       = 6,
    parameter int unsigned           ALUC_W     = 3,
    parameter logic [2**ALUC_W-1:0]  LONG_OPS   = 8'h60,
    parameter int unsigned           MC_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   id_i,
    input  logic              id_valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              mc_done_i,
    output logic              d_regsrc_o,
    output logic              stall_o,
    output logic              mc_start_o,
    output logic              e_alusrc_o,
    output logic              e_flagswrite_o,
    output logic [ALUC_W-1:0] e_aluctrl_o,
    output logic              m_regwrite_o,
    output logic              m_memtoreg_o,
    output logic              m_memwrite_o,
    output logic              w_regwrite_o,
    output logic              w_memtoreg_o,
    output logic              mc_timeout_o,
    output logic              illegal_o
);

    localparam int unsigned CNT_W = $clog2(MC_TIMEOUT + 1);

    ctrl_t            dec;
    ectrl_t           e_q, e_d;
    mctrl_t           m_q, m_d;
    wctrl_t           w_q, w_d;
    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             tmo_q, tmo_d;

    logic busy, cnt_max, e_long, mc_release, ex_hold, tmo_hit;

    ctrl_decoder #(.ID_W(ID_W)) u_dec (
        .id       (id_i),
        .id_valid (id_valid_i),
        .ctrl     (dec)
    );

    assign busy       = (state_q == BUSY);
    assign cnt_max    = (cnt_q == CNT_W'(MC_TIMEOUT));
    assign e_long     = e_q.regwrite & LONG_OPS[ALUC_W'(e_q.aluctrl)];
    assign mc_release = busy & (mc_done_i | cnt_max);
    assign ex_hold    = e_long & ~mc_release;
    assign tmo_hit    = busy & cnt_max & ~mc_done_i;

    // Multi-cycle handshake FSM; done takes priority over timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (e_long && !flush_i) begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush_i || mc_done_i) begin
                    state_d = IDLE;
                end else if (cnt_max) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage register next values; an aborted op leaves E without its write-back.
    always_comb begin
        e_d = e_q;
        if (flush_i) begin
            e_d = '0;
        end else if (ex_hold) begin
            e_d = e_q;
        end else if (stall_i) begin
            e_d = '0;
        end else begin
            e_d = dec.ex;
        end

        m_d = '0;
        if (!ex_hold) begin
            m_d.regwrite = e_q.regwrite & ~tmo_hit;
            m_d.memtoreg = e_q.memtoreg;
            m_d.memwrite = e_q.memwrite;
        end

        w_d.regwrite = m_q.regwrite;
        w_d.memtoreg = m_q.memtoreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            tmo_q   <= 1'b0;
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            tmo_q   <= tmo_d;
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
        end
    end

`ifdef DECODE_ERR_EN
    logic illegal_q;
    logic [1:0] id_cls;

    assign id_cls = id_i[ID_W-1 -: 2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (id_valid_i && (id_cls != CLASS_DP) && (id_cls != CLASS_MEM)) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_o = illegal_q;
`else
    assign illegal_o = 1'b0;
`endif

    assign d_regsrc_o     = dec.regsrc;
    assign stall_o        = ex_hold | stall_i;
    assign mc_start_o     = start_q;
    assign e_alusrc_o     = e_q.alusrc;
    assign e_flagswrite_o = e_q.flagswrite;
    assign e_aluctrl_o    = ALUC_W'(e_q.aluctrl);
    assign m_regwrite_o   = m_q.regwrite;
    assign m_memtoreg_o   = m_q.memtoreg;
    assign m_memwrite_o   = m_q.memwrite;
    assign w_regwrite_o   = w_q.regwrite;
    assign w_memtoreg_o   = w_q.memtoreg;
    assign mc_timeout_o   = tmo_q;

endmodule
